// File: rtl/rst_seq_pkg.sv
// Shared definitions for the board reset sequencer: state encoding, default
// 12 MHz timing constants and the state-to-output decode.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST     = 3'd0,
    WAIT_LOCK   = 3'd1,
    LOCK_STABLE = 3'd2,
    REL_CORE    = 3'd3,
    RUN         = 3'd4,
    FAULT       = 3'd5
  } rst_state_t;

  // Defaults for a 12 MHz OSCCLK.
  localparam int unsigned DEF_PLL_RST_CYCLES      = 32'd12;     // 1 us
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 32'd1200;   // 100 us
  localparam int unsigned DEF_STAGE_GAP_CYCLES    = 32'd16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 32'd12000;  // 1 ms
  localparam int unsigned DEF_MAX_RETRIES         = 32'd3;

  typedef struct packed {
    logic pll_rst;
    logic core_rst;
    logic periph_rst;
    logic rst_done;
    logic fault;
  } rst_outs_t;

  localparam rst_outs_t RESET_OUTS = '{
    pll_rst:    1'b1,
    core_rst:   1'b1,
    periph_rst: 1'b1,
    rst_done:   1'b0,
    fault:      1'b0
  };

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Output levels for each state. The reset order (pll, core, periph) is
  // encoded here so every state respects the release ordering.
  function automatic rst_outs_t decode_outs(input rst_state_t s);
    rst_outs_t o;
    o = RESET_OUTS;
    case (s)
      PLL_RST: begin
        o = RESET_OUTS;
      end
      WAIT_LOCK, LOCK_STABLE: begin
        o.pll_rst = 1'b0;
      end
      REL_CORE: begin
        o.pll_rst  = 1'b0;
        o.core_rst = 1'b0;
      end
      RUN: begin
        o.pll_rst    = 1'b0;
        o.core_rst   = 1'b0;
        o.periph_rst = 1'b0;
        o.rst_done   = 1'b1;
      end
      FAULT: begin
        o.fault = 1'b1;
      end
      default: begin
        o = RESET_OUTS;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous status inputs, with a
// synchronous active-high reset that clears both stages.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two back-to-back capture stages; only sync_r is safe to use.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/rst_sequencer.sv
// Board reset sequencer: holds the clock converter in reset, waits for a
// stable lock, then releases core and peripheral resets in order. Lock
// timeouts are retried a bounded number of times before a sticky fault.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                             OSCCLK,
  input  logic                             EXTRST,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic                             core_rst,
  output logic                             periph_rst,
  output logic                             rst_done,
  output logic                             fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

  localparam int unsigned MAX_CYCLES = max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                            max2(STAGE_GAP_CYCLES, LOCK_TIMEOUT_CYCLES));
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

  // Counter values seen on the last cycle of each timed state.
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRIES);

  rst_state_t       state_r;
  rst_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [RTY_W-1:0] retry_r;
  logic [RTY_W-1:0] retry_nxt_s;
  rst_outs_t        outs_r;
  logic             lock_s;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (OSCCLK),
    .rst (EXTRST),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Next-state and retry bookkeeping; lock decisions only use the synchronised lock.
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_r;
    case (state_r)
      PLL_RST: begin
        if (cnt_r >= PLL_LAST) begin
          state_nxt_s = WAIT_LOCK;
        end else begin
          state_nxt_s = PLL_RST;
        end
      end
      WAIT_LOCK: begin
        // Lock has priority over a coincident timeout.
        if (lock_s) begin
          state_nxt_s = LOCK_STABLE;
        end else if (cnt_r >= TIMEOUT_LAST) begin
          if (retry_r < RETRY_LIMIT) begin
            retry_nxt_s = retry_r + RTY_W'(1'b1);
            state_nxt_s = PLL_RST;
          end else begin
            state_nxt_s = FAULT;
          end
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      LOCK_STABLE: begin
        // A drop on the final counting cycle still falls back.
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
        end else if (cnt_r >= STABLE_LAST) begin
          state_nxt_s = REL_CORE;
        end else begin
          state_nxt_s = LOCK_STABLE;
        end
      end
      REL_CORE: begin
        if (!lock_s) begin
          state_nxt_s = PLL_RST;
        end else if (cnt_r >= GAP_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = REL_CORE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt_s = PLL_RST;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FAULT: begin
        state_nxt_s = FAULT;
      end
      default: begin
        state_nxt_s = PLL_RST;
      end
    endcase
  end

  // Dwell counter: restarts on every state change and holds at all-ones instead of wrapping.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (state_nxt_s != state_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = CNT_MAX;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1'b1);
    end
  end

  // State, dwell counter and retry count registers.
  always_ff @(posedge OSCCLK) begin
    if (EXTRST) begin
      state_r <= PLL_RST;
      cnt_r   <= {CNT_W{1'b0}};
      retry_r <= {RTY_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      retry_r <= retry_nxt_s;
    end
  end

  // Output register decoded from the current state, trailing it by one cycle.
  always_ff @(posedge OSCCLK) begin
    if (EXTRST) begin
      outs_r <= RESET_OUTS;
    end else begin
      outs_r <= decode_outs(state_r);
    end
  end

  assign pll_rst    = outs_r.pll_rst;
  assign core_rst   = outs_r.core_rst;
  assign periph_rst = outs_r.periph_rst;
  assign rst_done   = outs_r.rst_done;
  assign fault      = outs_r.fault;
  assign retry_cnt  = retry_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer using shortened timing parameters and
// an elapsed-time reference model of the reset sequence.
module tb_rst_sequencer;

  localparam int PLL_CYC = 4;
  localparam int LS_CYC  = 8;
  localparam int GAP_CYC = 3;
  localparam int TO_CYC  = 20;
  localparam int MAX_RTY = 2;
  // Lock sample -> 2 synchroniser cycles -> LS_CYC stable cycles -> output register.
  localparam int LOCK_TO_CORE = 2 + LS_CYC + 1;

  localparam int P_PLL = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3, P_RUN = 4, P_FAULT = 5;
  // {pll_rst, core_rst, periph_rst, rst_done, fault}
  localparam logic [4:0] RST_VEC   = 5'b11100;
  localparam logic [4:0] FAULT_VEC = 5'b11101;

  logic       OSCCLK = 1'b0;
  logic       EXTRST;
  logic       pll_locked;
  logic       pll_rst, core_rst, periph_rst, rst_done, fault;
  logic [1:0] retry_cnt;
  logic [4:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int         cyc = 0;
  int         m_phase = P_PLL;
  int         m_entered = 0;
  int         m_retry = 0;
  logic [4:0] m_out = RST_VEC;
  logic       hist[$];

  rst_sequencer #(
    .PLL_RST_CYCLES      (PLL_CYC),
    .LOCK_STABLE_CYCLES  (LS_CYC),
    .STAGE_GAP_CYCLES    (GAP_CYC),
    .LOCK_TIMEOUT_CYCLES (TO_CYC),
    .MAX_RETRIES         (MAX_RTY)
  ) dut (
    .OSCCLK     (OSCCLK),
    .EXTRST     (EXTRST),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .core_rst   (core_rst),
    .periph_rst (periph_rst),
    .rst_done   (rst_done),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  assign obs = {pll_rst, core_rst, periph_rst, rst_done, fault};

  always #5 OSCCLK = ~OSCCLK;

  function automatic logic [4:0] phase_outputs(input int ph);
    case (ph)
      P_PLL:          return 5'b11100;
      P_WAIT, P_STAB: return 5'b01100;
      P_REL:          return 5'b00100;
      P_RUN:          return 5'b00010;
      P_FAULT:        return 5'b11101;
      default:        return RST_VEC;
    endcase
  endfunction

  // Advance the model by one clock edge. 'spent' is the number of edges
  // spent in the current phase including this one.
  task automatic model_edge(input logic ext, input logic lk);
    logic ls;
    int   spent;
    int   nxt;
    cyc++;
    if (ext) begin
      m_phase   = P_PLL;
      m_entered = cyc;
      m_retry   = 0;
      m_out     = RST_VEC;
      hist      = '{1'b0, 1'b0};
    end else begin
      ls    = hist[1];  // lock sampled two edges ago
      spent = cyc - m_entered;
      m_out = phase_outputs(m_phase);
      nxt   = m_phase;
      case (m_phase)
        P_PLL:  if (spent >= PLL_CYC) nxt = P_WAIT;
        P_WAIT: begin
          if (ls) nxt = P_STAB;
          else if (spent >= TO_CYC) begin
            if (m_retry < MAX_RTY) begin
              m_retry++;
              nxt = P_PLL;
            end else nxt = P_FAULT;
          end
        end
        P_STAB: if (!ls) nxt = P_WAIT; else if (spent >= LS_CYC) nxt = P_REL;
        P_REL:  if (!ls) nxt = P_PLL; else if (spent >= GAP_CYC) nxt = P_RUN;
        P_RUN:  if (!ls) nxt = P_PLL;
        default: nxt = m_phase;
      endcase
      if (nxt != m_phase) begin
        m_phase   = nxt;
        m_entered = cyc;
      end
      hist.push_front(lk);
      void'(hist.pop_back());
    end
  endtask

  task automatic tick(input logic ext, input logic lk);
    EXTRST     = ext;
    pll_locked = lk;
    @(posedge OSCCLK);
    model_edge(ext, lk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)));
      n_cmp++;
      if (obs !== RST_VEC) begin
        n_bad++;
        $display("FAIL reset_outputs got=%b want=%b", obs, RST_VEC);
      end
      n_cmp++;
      if (retry_cnt !== 2'd0) begin
        n_bad++;
        $display("FAIL reset_retry got=%0d want=0", retry_cnt);
      end
    end
  endtask

  task automatic test_nominal();
    int fall;
    int n;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    fall = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 1'b0);
      if (!pll_rst && fall == 0) fall = i;
    end
    n_cmp++;
    if (fall != PLL_CYC + 1) begin
      n_bad++;
      $display("FAIL nominal_pll_release tick=%0d want=%0d", fall, PLL_CYC + 1);
    end
    tick(1'b0, 1'b1);
    n = 0;
    while (core_rst && n < 100) begin tick(1'b0, 1'b1); n++; end
    n_cmp++;
    if (n != LOCK_TO_CORE) begin
      n_bad++;
      $display("FAIL nominal_core_release cycles=%0d want=%0d", n, LOCK_TO_CORE);
    end
    n = 0;
    while (periph_rst && n < 100) begin tick(1'b0, 1'b1); n++; end
    n_cmp++;
    if (n != GAP_CYC) begin
      n_bad++;
      $display("FAIL nominal_periph_gap cycles=%0d want=%0d", n, GAP_CYC);
    end
    n_cmp++;
    if (obs !== 5'b00010 || retry_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL nominal_run got=%b retry=%0d want=00010 retry=0", obs, retry_cnt);
    end
  endtask

  task automatic test_glitch();
    int n;
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n = 0;
    while (core_rst && n < 100) begin tick(1'b0, 1'b1); n++; end
    n_cmp++;
    if (n != LOCK_TO_CORE) begin
      n_bad++;
      $display("FAIL glitch_core_release cycles=%0d want=%0d", n, LOCK_TO_CORE);
    end
    n_cmp++;
    if (retry_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL glitch_retry got=%0d want=0", retry_cnt);
    end
  endtask

  task automatic test_simultaneous();
    int k_rel;
    int n;
    // Lock seen by the decision logic exactly on the timeout cycle: lock wins.
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    for (int k = 1; k <= PLL_CYC + TO_CYC - 3; k++) tick(1'b0, 1'b0);
    k_rel = 0;
    for (int k = PLL_CYC + TO_CYC - 2; k <= 60; k++) begin
      tick(1'b0, 1'b1);
      if (k == PLL_CYC + TO_CYC) begin
        n_cmp++;
        if (retry_cnt !== 2'd0 || fault !== 1'b0) begin
          n_bad++;
          $display("FAIL lock_vs_timeout retry=%0d fault=%b want retry=0 fault=0", retry_cnt, fault);
        end
      end
      if (!core_rst && k_rel == 0) k_rel = k;
    end
    n_cmp++;
    if (k_rel != PLL_CYC + TO_CYC - 2 + LOCK_TO_CORE) begin
      n_bad++;
      $display("FAIL lock_vs_timeout_release tick=%0d want=%0d", k_rel, PLL_CYC + TO_CYC - 2 + LOCK_TO_CORE);
    end
    // One cycle later the timeout fires first and a retry is consumed.
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    for (int k = 1; k <= PLL_CYC + TO_CYC - 2; k++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    n_cmp++;
    if (retry_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL late_lock_retry got=%0d want=1", retry_cnt);
    end
    // Lock drop landing on the final LOCK_STABLE counting cycle.
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < LS_CYC; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n = 0;
    while (core_rst && n < 100) begin tick(1'b0, 1'b1); n++; end
    n_cmp++;
    if (n != LOCK_TO_CORE) begin
      n_bad++;
      $display("FAIL final_cycle_drop cycles=%0d want=%0d", n, LOCK_TO_CORE);
    end
  endtask

  task automatic test_never_lock();
    int run, good, odd, t_r1, t_r2, t_f;
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    run = 0; good = 0; odd = 0; t_r1 = 0; t_r2 = 0; t_f = 0;
    for (int k = 1; k <= 130; k++) begin
      tick(1'b0, 1'b0);
      if (pll_rst) run++;
      else begin
        if (run == PLL_CYC) good++;
        else if (run != 0) odd++;
        run = 0;
      end
      if (retry_cnt == 2'd1 && t_r1 == 0) t_r1 = k;
      if (retry_cnt == 2'd2 && t_r2 == 0) t_r2 = k;
      if (fault && t_f == 0) t_f = k;
    end
    n_cmp++;
    if (good != MAX_RTY + 1 || odd != 0) begin
      n_bad++;
      $display("FAIL never_lock_pulses good=%0d odd=%0d want good=%0d odd=0", good, odd, MAX_RTY + 1);
    end
    n_cmp++;
    if (t_r1 != PLL_CYC + TO_CYC || t_r2 != 2 * (PLL_CYC + TO_CYC)) begin
      n_bad++;
      $display("FAIL never_lock_retry_times r1=%0d r2=%0d want %0d %0d", t_r1, t_r2,
               PLL_CYC + TO_CYC, 2 * (PLL_CYC + TO_CYC));
    end
    n_cmp++;
    if (t_f != 3 * (PLL_CYC + TO_CYC) + 1) begin
      n_bad++;
      $display("FAIL never_lock_fault_time tick=%0d want=%0d", t_f, 3 * (PLL_CYC + TO_CYC) + 1);
    end
    n_cmp++;
    if (obs !== FAULT_VEC || retry_cnt !== 2'd2) begin
      n_bad++;
      $display("FAIL never_lock_final got=%b retry=%0d want=%b retry=2", obs, retry_cnt, FAULT_VEC);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    n = 0;
    while (!rst_done && n < 100) begin tick(1'b0, 1'b1); n++; end
    n_cmp++;
    if (!rst_done) begin
      n_bad++;
      $display("FAIL lock_loss_reach_run rst_done=%b want=1", rst_done);
    end
    tick(1'b0, 1'b0);
    n = 0;
    while (!pll_rst && n < 20) begin tick(1'b0, 1'b0); n++; end
    n_cmp++;
    if (n != 3 || obs !== RST_VEC) begin
      n_bad++;
      $display("FAIL lock_loss_reassert cycles=%0d got=%b want 3 cycles %b", n, obs, RST_VEC);
    end
    n = 0;
    while (!rst_done && n < 100) begin tick(1'b0, 1'b1); n++; end
    n_cmp++;
    if (!rst_done || retry_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL lock_loss_restart rst_done=%b retry=%0d want 1 0", rst_done, retry_cnt);
    end
  endtask

  task automatic test_extrst();
    int n;
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    n = 0;
    while (!fault && n < 200) begin tick(1'b0, 1'b0); n++; end
    tick(1'b1, 1'b0);
    n_cmp++;
    if (obs !== RST_VEC || retry_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL extrst_in_fault got=%b retry=%0d want=%b retry=0", obs, retry_cnt, RST_VEC);
    end
    // Consume one retry, then interrupt LOCK_STABLE part way through.
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
    n = 0;
    while (!(m_phase == P_STAB && cyc - m_entered >= 3) && n < 100) begin tick(1'b0, 1'b1); n++; end
    tick(1'b1, 1'b1);
    n_cmp++;
    if (obs !== RST_VEC || retry_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL extrst_in_stable got=%b retry=%0d want=%b retry=0", obs, retry_cnt, RST_VEC);
    end
    n = 0;
    while (pll_rst && n < 20) begin tick(1'b0, 1'b1); n++; end
    n_cmp++;
    if (n != PLL_CYC + 1) begin
      n_bad++;
      $display("FAIL extrst_restart_pll cycles=%0d want=%0d", n, PLL_CYC + 1);
    end
  endtask

  task automatic test_random();
    logic lk;
    logic ext;
    int   hold;
    lk   = 1'b0;
    hold = 0;
    for (int i = 0; i < 10000; i++) begin
      if (hold == 0) begin
        lk = ~lk;
        if (lk) hold = int'($urandom_range(1, 40));
        else if ($urandom_range(0, 7) == 0) hold = int'($urandom_range(20, 70));
        else hold = int'($urandom_range(1, 12));
      end
      hold--;
      ext = ($urandom_range(0, 999) == 0) || (m_phase == P_FAULT && $urandom_range(0, 29) == 0);
      tick(ext, lk);
      n_cmp++;
      if (obs !== m_out) begin
        n_bad++;
        $display("FAIL random_outputs cyc=%0d got=%b want=%b", cyc, obs, m_out);
      end
      n_cmp++;
      if (retry_cnt !== 2'(m_retry)) begin
        n_bad++;
        $display("FAIL random_retry cyc=%0d got=%0d want=%0d", cyc, retry_cnt, m_retry);
      end
      n_cmp++;
      if ((!periph_rst && core_rst) || (!core_rst && pll_rst)) begin
        n_bad++;
        $display("FAIL ordering_invariant cyc=%0d got pll/core/periph=%b%b%b", cyc, pll_rst, core_rst, periph_rst);
      end
    end
  endtask

  initial begin
    EXTRST     = 1'b1;
    pll_locked = 1'b0;
    hist       = '{1'b0, 1'b0};
    test_reset();
    test_nominal();
    test_glitch();
    test_simultaneous();
    test_never_lock();
    test_lock_loss();
    test_extrst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
